// File: rtl/axi_rd_responder.sv
// axi_rd_responder: AXI4 read-channel subordinate in front of a 1-cycle-latency SRAM.
// Accepts one AR at a time and issues one SRAM read per beat while output credit
// allows. Returned words queue in a 2-entry {id,data,resp,last} FIFO that drives R.
// Optional macro AXI_RD_ERR_EN: out-of-span beats and illegal WRAP lengths answer
// SLVERR with zero data and no SRAM read. Without it, addresses alias modulo the span.
module axi_rd_responder #(
  parameter int AXI_IW = 4,
  parameter int AXI_AW = 32,
  parameter int AXI_DW = 64,
  parameter int AXI_LW = 8,
  parameter int AXI_SW = 3,
  parameter int MEM_AW = 12
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [AXI_IW-1:0] ARID,
  input  logic [AXI_AW-1:0] ARADDR,
  input  logic [AXI_LW-1:0] ARLEN,
  input  logic [AXI_SW-1:0] ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [AXI_IW-1:0] RID,
  output logic [AXI_DW-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  output logic              mem_rd_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [AXI_DW-1:0] mem_rdata
);

  localparam int NB     = AXI_DW / 8;
  localparam int BO     = $clog2(NB);
  localparam int SPAN_W = MEM_AW + BO;
  localparam logic [AXI_SW-1:0] BO_SZ  = AXI_SW'(BO);
  localparam logic [AXI_AW-1:0] ONE_AW = {{(AXI_AW-1){1'b0}}, 1'b1};
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

  // WRAP is only defined for 2, 4, 8 or 16 beats
  function automatic logic wrap_len_ok(input logic [AXI_LW-1:0] len);
    logic ok;
    case (len)
      AXI_LW'(1), AXI_LW'(3), AXI_LW'(7), AXI_LW'(15): ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Address of the beat following addr; INCR wraps at the full address width
  function automatic logic [AXI_AW-1:0] next_beat_addr(input logic [AXI_AW-1:0] addr,
                                                       input logic [AXI_LW-1:0] len,
                                                       input logic [AXI_SW-1:0] size,
                                                       input logic [1:0]        burst);
    logic [AXI_AW-1:0] step;
    logic [AXI_AW-1:0] wmask;
    logic [AXI_AW-1:0] nxt;
    step  = ONE_AW << size;
    wmask = (({{(AXI_AW-AXI_LW){1'b0}}, len} + ONE_AW) << size) - ONE_AW;
    case (burst)
      BURST_FIXED: nxt = addr;
      BURST_WRAP: begin
        if (wrap_len_ok(len)) nxt = (addr & ~wmask) | ((addr + step) & wmask);
        else                  nxt = addr + step;
      end
      default: nxt = addr + step;
    endcase
    return nxt;
  endfunction

  state_t              state_r, state_nxt;
  logic                arready_r;
  logic [AXI_IW-1:0]   id_r;
  logic [AXI_AW-1:0]   addr_r;
  logic [AXI_LW-1:0]   len_r, beat_r;
  logic [AXI_SW-1:0]   size_r;
  logic [1:0]          burst_r;
  logic                inf_v_r, inf_last_r, inf_err_r;
  logic [AXI_IW-1:0]   inf_id_r;
  logic                rvalid_r, rlast_r, sk_v_r, sk_last_r;
  logic [AXI_IW-1:0]   rid_r, sk_id_r;
  logic [AXI_DW-1:0]   rdata_r, sk_data_r;
  logic [1:0]          rresp_r, sk_resp_r;

  logic                ar_hs_s, pop_s, credit_s, issue_s, beat_err_s, last_beat_s;
  logic [1:0]          cnt_s;
  logic [AXI_DW-1:0]   push_data_s;
  logic [1:0]          push_resp_s;

  assign ar_hs_s     = ARVALID & arready_r;
  assign pop_s       = rvalid_r & RREADY;
  assign last_beat_s = (beat_r == len_r);
  assign cnt_s       = {1'b0, rvalid_r} + {1'b0, sk_v_r} + {1'b0, inf_v_r};
  assign issue_s     = (state_r == BURST) & credit_s;
  assign push_data_s = inf_err_r ? {AXI_DW{1'b0}} : mem_rdata;
  assign push_resp_s = inf_err_r ? 2'b10 : 2'b00;

  // Credit: queued beats plus the read in flight must leave a free slot; a pop this cycle counts
  always_comb begin
    credit_s = 1'b0;
    if ((cnt_s - {1'b0, pop_s}) < 2'd2) credit_s = 1'b1;
    else                                credit_s = 1'b0;
  end

`ifdef AXI_RD_ERR_EN
  // Beats outside the memory span, and every beat of an illegal WRAP, answer SLVERR
  always_comb begin
    beat_err_s = 1'b0;
    if (addr_r[AXI_AW-1:SPAN_W] != {(AXI_AW-SPAN_W){1'b0}}) beat_err_s = 1'b1;
    else if ((burst_r == BURST_WRAP) && !wrap_len_ok(len_r)) beat_err_s = 1'b1;
    else beat_err_s = 1'b0;
  end
`else
  // Every beat reads memory; high address bits simply alias
  always_comb begin
    beat_err_s = 1'b0;
  end
`endif

  // Next-state logic: leave BURST once the read for the final beat is issued
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (ar_hs_s) state_nxt = BURST;
        else         state_nxt = IDLE;
      end
      BURST: begin
        if (issue_s && last_beat_s) state_nxt = IDLE;
        else                        state_nxt = BURST;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, registered ARREADY and burst context (latched on AR, advanced per issued beat)
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_r   <= IDLE;
      arready_r <= 1'b0;
      id_r      <= {AXI_IW{1'b0}};
      addr_r    <= {AXI_AW{1'b0}};
      len_r     <= {AXI_LW{1'b0}};
      size_r    <= {AXI_SW{1'b0}};
      burst_r   <= 2'b00;
      beat_r    <= {AXI_LW{1'b0}};
    end else begin
      state_r   <= state_nxt;
      arready_r <= (state_nxt == IDLE);
      if (ar_hs_s) begin
        id_r    <= ARID;
        addr_r  <= ARADDR;
        len_r   <= ARLEN;
        size_r  <= (ARSIZE > BO_SZ) ? BO_SZ : ARSIZE;
        burst_r <= ARBURST;
        beat_r  <= {AXI_LW{1'b0}};
      end else if (issue_s) begin
        addr_r  <= next_beat_addr(addr_r, len_r, size_r, burst_r);
        beat_r  <= beat_r + {{(AXI_LW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Sideband for the read in flight, aligned with the SRAM data one cycle later
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      inf_v_r    <= 1'b0;
      inf_id_r   <= {AXI_IW{1'b0}};
      inf_last_r <= 1'b0;
      inf_err_r  <= 1'b0;
    end else begin
      inf_v_r    <= issue_s;
      inf_id_r   <= id_r;
      inf_last_r <= last_beat_s;
      inf_err_r  <= beat_err_s;
    end
  end

  // Output FIFO: head registers drive R directly, skid holds the second entry
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rvalid_r  <= 1'b0;
      rid_r     <= {AXI_IW{1'b0}};
      rdata_r   <= {AXI_DW{1'b0}};
      rresp_r   <= 2'b00;
      rlast_r   <= 1'b0;
      sk_v_r    <= 1'b0;
      sk_id_r   <= {AXI_IW{1'b0}};
      sk_data_r <= {AXI_DW{1'b0}};
      sk_resp_r <= 2'b00;
      sk_last_r <= 1'b0;
    end else if (!rvalid_r || pop_s) begin
      if (sk_v_r) begin
        rvalid_r  <= 1'b1;
        rid_r     <= sk_id_r;
        rdata_r   <= sk_data_r;
        rresp_r   <= sk_resp_r;
        rlast_r   <= sk_last_r;
        sk_v_r    <= inf_v_r;
        sk_id_r   <= inf_id_r;
        sk_data_r <= push_data_s;
        sk_resp_r <= push_resp_s;
        sk_last_r <= inf_last_r;
      end else begin
        rvalid_r <= inf_v_r;
        sk_v_r   <= 1'b0;
        if (inf_v_r) begin
          rid_r   <= inf_id_r;
          rdata_r <= push_data_s;
          rresp_r <= push_resp_s;
          rlast_r <= inf_last_r;
        end
      end
    end else if (inf_v_r) begin
      sk_v_r    <= 1'b1;
      sk_id_r   <= inf_id_r;
      sk_data_r <= push_data_s;
      sk_resp_r <= push_resp_s;
      sk_last_r <= inf_last_r;
    end
  end

  assign ARREADY   = arready_r;
  assign RVALID    = rvalid_r;
  assign RID       = rid_r;
  assign RDATA     = rdata_r;
  assign RRESP     = rresp_r;
  assign RLAST     = rlast_r;
  assign mem_rd_en = issue_s & ~beat_err_s;
  assign mem_addr  = addr_r[SPAN_W-1:BO];

endmodule

// File: tb/tb_axi_rd_responder.sv
// Directed bench for axi_rd_responder (default parameters). A vector table covers the
// burst types and boundaries; hand-written sequences cover back-to-back AR and reset
// mid-burst. Expected SLVERR beats follow AXI_RD_ERR_EN when the bench is built with it.
module tb_axi_rd_responder;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  ARID;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic        mem_rd_en;
  logic [11:0] mem_addr;
  logic [63:0] mem_rdata = 64'h0;

`ifdef AXI_RD_ERR_EN
  localparam bit ERR_BUILD = 1'b1;
`else
  localparam bit ERR_BUILD = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [3:0]        id;
    logic [31:0]       addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              tog;
    logic [7:0][11:0]  words;
    logic [7:0]        errm;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  beat_t rq[$];
  beat_t cur;
  beat_t held;
  bit    stall_p = 1'b0;
  int    issued = 0;
  int    retired = 0;
  vec_t  vecs[12];

  axi_rd_responder dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  initial forever #5 ACLK = ~ACLK;

  function automatic logic [63:0] memval(input logic [11:0] w);
    return {20'hA5A50, w, 20'h3C3C3, ~w};
  endfunction

  // SRAM model: data valid the cycle after the strobe, garbage otherwise
  always @(posedge ACLK) begin
    if (mem_rd_en) mem_rdata <= memval(mem_addr);
    else           mem_rdata <= 64'hBAD0_BAD0_BAD0_BAD0;
  end

  assign cur = {RID, RDATA, RRESP, RLAST};

  // R monitor: collect retired beats, check stability under stall and outstanding reads
  always @(negedge ACLK) begin
    if (ARESET) begin
      stall_p = 1'b0;
      issued  = 0;
      retired = 0;
    end else begin
      if (stall_p) begin
        checks++;
        if (!(RVALID === 1'b1 && cur === held)) begin
          errors++;
          $display("FAIL r_stable: got valid=%b id=%h data=%h last=%b, want valid=1 id=%h data=%h last=%b",
                   RVALID, RID, RDATA, RLAST, held.id, held.data, held.last);
        end
      end
      if (RVALID && RREADY) begin
        rq.push_back(cur);
        retired++;
      end
      stall_p = RVALID && !RREADY;
      held    = cur;
      if (mem_rd_en) begin
        issued++;
        checks++;
        if (issued - retired > 2) begin
          errors++;
          $display("FAIL outstanding: got %0d reads outstanding, want <= 2", issued - retired);
        end
      end
    end
  end

  function automatic vec_t mkv(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input bit tog,
                               input int w0, input int w1, input int w2, input int w3,
                               input int w4, input int w5, input int w6, input int w7,
                               input logic [7:0] errm);
    vec_t v;
    v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst; v.tog = tog;
    v.words[0] = 12'(w0); v.words[1] = 12'(w1); v.words[2] = 12'(w2); v.words[3] = 12'(w3);
    v.words[4] = 12'(w4); v.words[5] = 12'(w5); v.words[6] = 12'(w6); v.words[7] = 12'(w7);
    v.errm = errm;
    return v;
  endfunction

  function automatic beat_t exp_beat(input logic [3:0] id, input logic [11:0] w, input bit err, input bit last);
    beat_t b;
    b.id   = id;
    b.data = err ? 64'h0 : memval(w);
    b.resp = err ? 2'b10 : 2'b00;
    b.last = last;
    return b;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic cmp_beat(input string name, input int idx, input beat_t act, input beat_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s beat %0d: got id=%h data=%h resp=%b last=%b, want id=%h data=%h resp=%b last=%b",
               name, idx, act.id, act.data, act.resp, act.last, exp.id, exp.data, exp.resp, exp.last);
    end
  endtask

  // Present an AR and hold it until accepted (bounded); keep leaves ARVALID high afterwards
  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input bit keep);
    bit hs;
    hs = 1'b0;
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    for (int c = 0; c < 50 && !hs; c++) begin
      @(negedge ACLK);
      if (ARREADY) hs = 1'b1;
      @(posedge ACLK); #1;
    end
    if (!keep) ARVALID = 1'b0;
    checks++;
    if (!hs) begin
      errors++;
      $display("FAIL ar_handshake id=%0d: got no ARREADY, want accept", id);
    end
  endtask

  // Wait (bounded) for n beats, optionally toggling RREADY each cycle, then confirm no extras
  task automatic wait_beats(input string name, input int n, input bit tog);
    for (int c = 0; c < 400 && rq.size() < n; c++) begin
      @(posedge ACLK); #1;
      if (tog) RREADY = !RREADY;
    end
    RREADY = 1'b1;
    repeat (4) begin @(posedge ACLK); #1; end
    checks++;
    if (rq.size() != n) begin
      errors++;
      $display("FAIL %s beat_count: got %0d, want %0d", name, rq.size(), n);
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    bit err0;
    rq.delete();
    RREADY = 1'b1;
    send_ar(v.id, v.addr, v.len, v.size, v.burst, 1'b0);
    @(negedge ACLK);
    err0 = ERR_BUILD && v.errm[0];
    if (err0) check({name, " first_read"}, {63'h0, mem_rd_en}, 64'h0);
    else      check({name, " first_read"}, {51'h0, mem_rd_en, mem_addr}, {51'h1, v.words[0]});
    @(posedge ACLK); #1;
    wait_beats(name, int'(v.len) + 1, v.tog);
    for (int i = 0; i <= int'(v.len); i++) begin
      if (i < rq.size())
        cmp_beat(name, i, rq[i], exp_beat(v.id, v.words[i], ERR_BUILD && v.errm[i], i == int'(v.len)));
    end
    @(negedge ACLK);
    check({name, " arready_after"}, {63'h0, ARREADY}, 64'h1);
    @(posedge ACLK); #1;
  endtask

  initial begin
    int sz;
    ARESET = 1'b1; ARVALID = 1'b0; ARID = 4'h0; ARADDR = 32'h0; ARLEN = 8'h0;
    ARSIZE = 3'h0; ARBURST = 2'b00; RREADY = 1'b1;

    vecs[0]  = mkv(4'd3,  32'h0000_0040, 8'd0, 3'd3, 2'b01, 1'b0,  8, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    vecs[1]  = mkv(4'd5,  32'h0000_0000, 8'd3, 3'd3, 2'b01, 1'b0,  0, 1, 2, 3, 0, 0, 0, 0, 8'h00);
    vecs[2]  = mkv(4'd6,  32'h0000_0018, 8'd3, 3'd3, 2'b10, 1'b0,  3, 0, 1, 2, 0, 0, 0, 0, 8'h00);
    vecs[3]  = mkv(4'd7,  32'h0000_0100, 8'd7, 3'd3, 2'b01, 1'b1, 32,33,34,35,36,37,38,39, 8'h00);
    vecs[4]  = mkv(4'd2,  32'h0000_0028, 8'd2, 3'd3, 2'b00, 1'b0,  5, 5, 5, 0, 0, 0, 0, 0, 8'h00);
    vecs[5]  = mkv(4'd4,  32'h0000_0004, 8'd3, 3'd2, 2'b01, 1'b1,  0, 1, 1, 2, 0, 0, 0, 0, 8'h00);
    vecs[6]  = mkv(4'd8,  32'h0000_0034, 8'd3, 3'd2, 2'b10, 1'b0,  6, 7, 7, 6, 0, 0, 0, 0, 8'h00);
    vecs[7]  = mkv(4'd9,  32'h0000_0018, 8'd2, 3'd3, 2'b10, 1'b0,  3, 4, 5, 0, 0, 0, 0, 0, 8'h07);
    vecs[8]  = mkv(4'd10, 32'h0000_0008, 8'd1, 3'd7, 2'b01, 1'b0,  1, 2, 0, 0, 0, 0, 0, 0, 8'h00);
    vecs[9]  = mkv(4'd11, 32'h0000_8010, 8'd0, 3'd3, 2'b01, 1'b0,  2, 0, 0, 0, 0, 0, 0, 0, 8'h01);
    vecs[10] = mkv(4'd12, 32'hFFFF_FFF8, 8'd1, 3'd3, 2'b01, 1'b1, 12'hFFF, 0, 0, 0, 0, 0, 0, 0, 8'h01);
    vecs[11] = mkv(4'd13, 32'h0000_0020, 8'd1, 3'd3, 2'b11, 1'b0,  4, 5, 0, 0, 0, 0, 0, 0, 8'h00);

    // Reset values, then ARREADY rises only after the first non-reset edge
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("reset_outputs", {ARREADY, RVALID, RLAST, RID, RRESP, mem_rd_en}, 64'h0);
    check("reset_rdata", RDATA, 64'h0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    check("arready_release", {63'h0, ARREADY}, 64'h0);
    @(posedge ACLK); #1;
    @(negedge ACLK);
    check("arready_idle", {63'h0, ARREADY}, 64'h1);
    @(posedge ACLK); #1;

    for (int i = 0; i < 12; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back AR with ARVALID held: IDs 1,1,2
    rq.delete();
    RREADY = 1'b1;
    send_ar(4'd1, 32'h0, 8'd1, 3'd3, 2'b01, 1'b1);
    send_ar(4'd2, 32'h80, 8'd0, 3'd3, 2'b01, 1'b0);
    wait_beats("b2b", 3, 1'b0);
    if (rq.size() == 3) begin
      cmp_beat("b2b", 0, rq[0], exp_beat(4'd1, 12'd0, 1'b0, 1'b0));
      cmp_beat("b2b", 1, rq[1], exp_beat(4'd1, 12'd1, 1'b0, 1'b1));
      cmp_beat("b2b", 2, rq[2], exp_beat(4'd2, 12'd16, 1'b0, 1'b1));
    end

    // Reset pulse mid-burst aborts it; a fresh AR afterwards behaves normally
    rq.delete();
    RREADY = 1'b1;
    send_ar(4'd14, 32'h200, 8'd7, 3'd3, 2'b01, 1'b0);
    for (int c = 0; c < 50 && rq.size() < 2; c++) begin @(posedge ACLK); #1; end
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    check("midreset_outputs", {RVALID, RLAST, ARREADY, mem_rd_en}, 64'h0);
    sz = rq.size();
    repeat (10) begin @(posedge ACLK); #1; end
    check("midreset_no_beats", 64'(rq.size()), 64'(sz));
    run_vec("after_reset", vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
